// File: rtl/conv_fft_tile_loader_if.sv
// Bundle between the FFT tile loader and its neighbours:
// cacheline input, FFT engine frames/spectra, spectrum read port, status.
interface conv_fft_tile_loader_if #(
  parameter int DATA_W    = 32,
  parameter int TILES     = 4,
  parameter int K         = 2,
  parameter int N         = 4,
  parameter int IMG_DEPTH = 8192,
  parameter int KER_DEPTH = 512
);
  localparam int CL_W = TILES*K*K*DATA_W;
  localparam int FR_W = TILES*N*N*DATA_W;
  localparam int SP_W = 2*FR_W;
  localparam int IAW  = $clog2(IMG_DEPTH);
  localparam int KAW  = $clog2(KER_DEPTH);

  logic            in_valid;
  logic            in_ready;
  logic            in_is_filter;
  logic            in_last;
  logic [CL_W-1:0] cacheline_in;

  logic             fft_next;
  logic [FR_W-1:0]  fft_frame;
  logic [TILES-1:0] fft_next_out;
  logic [SP_W-1:0]  fft_out;

  logic            rd_en;
  logic            rd_sel;
  logic [IAW-1:0]  rd_addr;
  logic            rd_valid;
  logic [SP_W-1:0] rd_data;

  logic [IAW:0]    img_count;
  logic [KAW:0]    ker_count;
  logic            load_done;
  logic            err;

  modport slave (
    input  in_valid, in_is_filter, in_last, cacheline_in,
    input  fft_next_out, fft_out,
    input  rd_en, rd_sel, rd_addr,
    output in_ready, fft_next, fft_frame,
    output rd_valid, rd_data,
    output img_count, ker_count, load_done, err
  );

  modport master (
    output in_valid, in_is_filter, in_last, cacheline_in,
    output fft_next_out, fft_out,
    output rd_en, rd_sel, rd_addr,
    input  in_ready, fft_next, fft_frame,
    input  rd_valid, rd_data,
    input  img_count, ker_count, load_done, err
  );
endinterface

// File: rtl/conv_fft_tile_loader.sv
// Unpacks cachelines into zero-padded FFT frames and stores returned spectra.
// Define CONV_FFT_KERNEL_FLIP_EN to rotate kernel tiles 180 deg (convolution).
module conv_fft_tile_loader #(
  parameter int DATA_W    = 32,
  parameter int TILES     = 4,
  parameter int K         = 2,
  parameter int N         = 4,
  parameter int IMG_DEPTH = 8192,
  parameter int KER_DEPTH = 512,
  parameter int MAX_OUT   = 8
) (
  input logic clk,
  input logic reset,
  conv_fft_tile_loader_if.slave io
);
  localparam int FR_W = TILES*N*N*DATA_W;
  localparam int SP_W = 2*FR_W;
  localparam int IAW  = $clog2(IMG_DEPTH);
  localparam int KAW  = $clog2(KER_DEPTH);
  localparam int ICW  = IAW + 1;
  localparam int KCW  = KAW + 1;
  localparam int OW   = $clog2(MAX_OUT);
  localparam int OCW  = OW + 1;

  typedef enum logic [1:0] {
    LOAD_IMAGE, LOAD_KERNEL, DRAIN, LOAD_DONE
  } state_e;

  typedef struct packed {
    logic filter;
    logic drop;
  } tag_t;

  state_e          state_q, state_d;
  logic            ker_seen_q, ker_seen_d;
  logic            ignore_q, ignore_d;
  logic [OCW-1:0]  outst_q, outst_d;
  logic [OW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            fft_next_q, fft_next_d;
  logic [FR_W-1:0] fft_frame_q, fft_frame_d;
  logic [ICW-1:0]  img_count_q, img_count_d;
  logic [KCW-1:0]  ker_count_q, ker_count_d;
  logic            load_done_q, load_done_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [SP_W-1:0] rd_data_q, rd_data_d;

  tag_t            tag_mem_q [MAX_OUT];
  logic [SP_W-1:0] img_mem [IMG_DEPTH];
  logic [SP_W-1:0] ker_mem [KER_DEPTH];

  logic            in_ready;
  logic            accept, reject, issue;
  logic            cap_all, cap_part, fifo_empty, pop;
  logic            img_full, ker_full, full_hit;
  logic            wr_img, wr_ker, go_done;
  tag_t            tag_h, tag_new;
  logic [FR_W-1:0] frame_pad;

  assign in_ready = (outst_q < OCW'(MAX_OUT)) &&
                    (state_q != LOAD_DONE);
  assign accept   = io.in_valid & in_ready;
  // image lines arriving once kernels have started are discarded
  assign reject   = accept & ~io.in_is_filter & ker_seen_q;
  assign issue    = accept & ~reject;

  assign img_full = img_count_q == ICW'(IMG_DEPTH);
  assign ker_full = ker_count_q == KCW'(KER_DEPTH);

  assign tag_new.filter = io.in_is_filter;
  assign tag_new.drop   = io.in_is_filter ? ker_full : img_full;

  assign cap_all    = &io.fft_next_out;
  assign cap_part   = (|io.fft_next_out) & ~cap_all;
  assign fifo_empty = outst_q == '0;
  // pulses after reset belong to abandoned frames until a new issue
  assign pop        = cap_all & ~ignore_q & ~fifo_empty;
  assign tag_h      = tag_mem_q[rd_ptr_q];
  assign full_hit   = tag_h.drop |
                      (tag_h.filter ? ker_full : img_full);
  assign wr_img     = pop & ~tag_h.filter & ~full_hit;
  assign wr_ker     = pop & tag_h.filter & ~full_hit;
  assign go_done    = (state_q == DRAIN) && fifo_empty && !accept;

  always_comb begin
    frame_pad = '0;
    for (int t = 0; t < TILES; t++) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
`ifdef CONV_FFT_KERNEL_FLIP_EN
          if (io.in_is_filter)
            frame_pad[((t*N+K-1-r)*N+K-1-c)*DATA_W +: DATA_W] =
              io.cacheline_in[((t*K+r)*K+c)*DATA_W +: DATA_W];
          else
            frame_pad[((t*N+r)*N+c)*DATA_W +: DATA_W] =
              io.cacheline_in[((t*K+r)*K+c)*DATA_W +: DATA_W];
`else
          frame_pad[((t*N+r)*N+c)*DATA_W +: DATA_W] =
            io.cacheline_in[((t*K+r)*K+c)*DATA_W +: DATA_W];
`endif
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ker_seen_d  = ker_seen_q | (accept & io.in_is_filter);
    ignore_d    = issue ? 1'b0 : ignore_q;
    outst_d     = outst_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fft_next_d  = issue;
    fft_frame_d = issue ? frame_pad : fft_frame_q;
    img_count_d = img_count_q;
    ker_count_d = ker_count_q;
    load_done_d = load_done_q | go_done;
    err_d       = err_q;
    rd_valid_d  = io.rd_en;
    rd_data_d   = rd_data_q;

    unique case ({issue, pop})
      2'b10:   outst_d = outst_q + OCW'(1);
      2'b01:   outst_d = outst_q - OCW'(1);
      default: outst_d = outst_q;
    endcase
    if (issue) wr_ptr_d = wr_ptr_q + OW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + OW'(1);
    if (wr_img) img_count_d = img_count_q + ICW'(1);
    if (wr_ker) ker_count_d = ker_count_q + KCW'(1);

    if (reject || (pop && full_hit)) err_d = 1'b1;
    if (!ignore_q && (cap_part || (cap_all && fifo_empty)))
      err_d = 1'b1;

    unique case (state_q)
      LOAD_IMAGE:
        if (accept && io.in_is_filter) state_d = LOAD_KERNEL;
      DRAIN:
        if (go_done) state_d = LOAD_DONE;
      default: state_d = state_q;
    endcase
    if (accept && io.in_last) state_d = DRAIN;

    if (io.rd_en)
      rd_data_d = io.rd_sel ? ker_mem[io.rd_addr[KAW-1:0]]
                            : img_mem[io.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_IMAGE;
      ker_seen_q  <= 1'b0;
      ignore_q    <= 1'b1;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fft_next_q  <= 1'b0;
      fft_frame_q <= '0;
      img_count_q <= '0;
      ker_count_q <= '0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ker_seen_q  <= ker_seen_d;
      ignore_q    <= ignore_d;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fft_next_q  <= fft_next_d;
      fft_frame_q <= fft_frame_d;
      img_count_q <= img_count_d;
      ker_count_q <= ker_count_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && issue) tag_mem_q[wr_ptr_q] <= tag_new;
    if (!reset && wr_img) img_mem[img_count_q[IAW-1:0]] <= io.fft_out;
    if (!reset && wr_ker) ker_mem[ker_count_q[KAW-1:0]] <= io.fft_out;
  end

  assign io.in_ready  = in_ready;
  assign io.fft_next  = fft_next_q;
  assign io.fft_frame = fft_frame_q;
  assign io.rd_valid  = rd_valid_q;
  assign io.rd_data   = rd_data_q;
  assign io.img_count = img_count_q;
  assign io.ker_count = ker_count_q;
  assign io.load_done = load_done_q;
  assign io.err       = err_q;
endmodule

// File: tb/tb_conv_fft_tile_loader.sv
// Bench for conv_fft_tile_loader: fake fixed-latency FFT engines,
// queue-based model of stored spectra, directed steps with random data.
module tb_conv_fft_tile_loader;
  localparam int DW  = 32;
  localparam int TL  = 4;
  localparam int K   = 2;
  localparam int N   = 4;
  localparam int ID  = 16;
  localparam int KD  = 8;
  localparam int MO  = 8;
  localparam int LAT = 5;
  localparam int CL_W = TL*K*K*DW;
  localparam int FR_W = TL*N*N*DW;
  localparam int SP_W = 2*FR_W;
  localparam int IAW  = $clog2(ID);
`ifdef CONV_FFT_KERNEL_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_cap = 0;
  int stall_until = 0;

  logic [FR_W-1:0] eng_f[$];
  int              eng_t[$];
  logic [SP_W-1:0] exp_img[$];
  logic [SP_W-1:0] exp_ker[$];

  conv_fft_tile_loader_if #(
    .DATA_W(DW), .TILES(TL), .K(K), .N(N),
    .IMG_DEPTH(ID), .KER_DEPTH(KD)
  ) bus ();

  conv_fft_tile_loader #(
    .DATA_W(DW), .TILES(TL), .K(K), .N(N),
    .IMG_DEPTH(ID), .KER_DEPTH(KD), .MAX_OUT(MO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame(r,c) takes tile(r,c), or tile(K-1-r,K-1-c) when flipped
  function automatic logic [FR_W-1:0] pad(
    input logic [CL_W-1:0] l, input bit flip);
    logic [FR_W-1:0] f;
    int sr, sc;
    f = '0;
    for (int t = 0; t < TL; t++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          sr = flip ? K-1-r : r;
          sc = flip ? K-1-c : c;
          f[((t*N+r)*N+c)*DW +: DW] = l[((t*K+sr)*K+sc)*DW +: DW];
        end
    return f;
  endfunction

  function automatic logic [SP_W-1:0] fake_fft(input logic [FR_W-1:0] f);
    logic [SP_W-1:0] s;
    logic [DW-1:0] v;
    s = '0;
    for (int b = 0; b < TL*N*N; b++) begin
      v = f[b*DW +: DW];
      s[b*2*DW +: DW]    = v*32'd3 + 32'(b) + 32'd1;
      s[b*2*DW+DW +: DW] = ~v ^ 32'(b*257);
    end
    return s;
  endfunction

  function automatic logic [CL_W-1:0] rnd_line();
    logic [CL_W-1:0] l;
    for (int i = 0; i < CL_W/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // fake engines: every frame returns LAT cycles after fft_next
  always @(negedge clk) begin
    if (bus.fft_next) begin
      eng_f.push_back(bus.fft_frame);
      eng_t.push_back(cyc);
    end
    if (cyc >= stall_until && eng_f.size() > 0 &&
        cyc >= eng_t[0] + LAT - 1) begin
      bus.fft_next_out = '1;
      bus.fft_out = fake_fft(eng_f[0]);
      last_cap = cyc + 1;
      void'(eng_f.pop_front());
      void'(eng_t.pop_front());
    end else begin
      bus.fft_next_out = '0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [SP_W-1:0] obs,
                     input logic [SP_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h required=%0h",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic check_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_fft_next", bus.fft_next, 0);
    chk("rst_fft_frame", bus.fft_frame, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_img_count", bus.img_count, 0);
    chk("rst_ker_count", bus.ker_count, 0);
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_err", bus.err, 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.rd_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_img.delete();
    exp_ker.delete();
  endtask

  task automatic send(input logic [CL_W-1:0] l, input bit filt,
                      input bit last, input bit issue);
    int n;
    n = 0;
    bus.cacheline_in = l;
    bus.in_is_filter = filt;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("accept_wait", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("fft_next", bus.fft_next, issue);
    if (issue) begin
      chk("fft_frame", bus.fft_frame, pad(l, FLIP && filt));
      if (filt) exp_ker.push_back(fake_fft(pad(l, FLIP && filt)));
      else      exp_img.push_back(fake_fft(pad(l, FLIP && filt)));
    end
  endtask

  task automatic rd(input bit sel, input int a,
                    input logic [SP_W-1:0] e, input string tag);
    bus.rd_en = 1'b1;
    bus.rd_sel = sel;
    bus.rd_addr = IAW'(a);
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_valid"}, bus.rd_valid, 1);
    chk(tag, bus.rd_data, e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.load_done && n < 300) begin
      tick();
      n++;
    end
    chk("load_done", bus.load_done, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (eng_f.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  initial begin
    logic [CL_W-1:0] lbit;
    logic [CL_W-1:0] l9;
    int kb;
    int n;
    bus.in_valid = 1'b0;
    bus.in_is_filter = 1'b0;
    bus.in_last = 1'b0;
    bus.cacheline_in = '0;
    bus.rd_en = 1'b0;
    bus.rd_sel = 1'b0;
    bus.rd_addr = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    check_reset();

    // 3 image + 2 kernel lines; single-sample lines probe padding
    lbit = '0;
    lbit[32 +: 32] = 32'd1;
    send(lbit, 1'b0, 1'b0, 1'b1);
    chk("pad_img_bin01", bus.fft_frame[32 +: 32], 1);
    send(rnd_line(), 1'b0, 1'b0, 1'b1);
    send(rnd_line(), 1'b0, 1'b0, 1'b1);
    send(lbit, 1'b1, 1'b0, 1'b1);
    kb = FLIP ? 128 : 32;
    chk("pad_ker_bin", bus.fft_frame[kb +: 32], 1);
    send(rnd_line(), 1'b1, 1'b1, 1'b1);
    wait_done();
    chk("done_latency", cyc - last_cap, 1);
    chk("img_count", bus.img_count, exp_img.size());
    chk("ker_count", bus.ker_count, exp_ker.size());
    chk("err_clean", bus.err, 0);
    chk("ready_when_done", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) rd(1'b0, i, exp_img[i], "rd_img");
    for (int i = 0; i < 2; i++) rd(1'b1, i, exp_ker[i], "rd_ker");
    tick();
    chk("rd_valid_idle", bus.rd_valid, 0);

    // backpressure with stalled engines
    wait_idle();
    do_reset();
    stall_until = cyc + 20;
    for (int i = 0; i < 8; i++) send(rnd_line(), 1'b0, 1'b0, 1'b1);
    chk("ready_drop", bus.in_ready, 0);
    l9 = rnd_line();
    bus.cacheline_in = l9;
    bus.in_is_filter = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.fft_next_out[0] && n < 100) begin
      tick();
      n++;
    end
    chk("ready_held", bus.in_ready, 0);
    tick();
    chk("ready_back", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("fft_next_l9", bus.fft_next, 1);
    chk("fft_frame_l9", bus.fft_frame, pad(l9, 1'b0));
    exp_img.push_back(fake_fft(pad(l9, 1'b0)));
    send(rnd_line(), 1'b0, 1'b1, 1'b1);
    wait_done();
    chk("bp_img_count", bus.img_count, exp_img.size());
    chk("bp_err", bus.err, 0);
    for (int i = 0; i < 10; i++) rd(1'b0, i, exp_img[i], "bp_rd");

    // image line after a kernel line
    wait_idle();
    do_reset();
    send(rnd_line(), 1'b1, 1'b0, 1'b1);
    send(rnd_line(), 1'b0, 1'b0, 1'b0);
    chk("reject_err", bus.err, 1);
    wait_idle();
    chk("reject_img_count", bus.img_count, exp_img.size());
    chk("reject_ker_count", bus.ker_count, exp_ker.size());

    // image region overflow
    wait_idle();
    do_reset();
    for (int i = 0; i <= ID; i++)
      send(rnd_line(), 1'b0, i == ID, 1'b1);
    wait_done();
    chk("full_img_count", bus.img_count,
        exp_img.size() > ID ? ID : exp_img.size());
    chk("full_err", bus.err, exp_img.size() > ID);
    rd(1'b0, ID-1, exp_img[ID-1], "full_rd_last");
    rd(1'b0, 0, exp_img[0], "full_rd_first");

    // reset with frames in flight
    wait_idle();
    do_reset();
    for (int i = 0; i < 3; i++) send(rnd_line(), 1'b0, 1'b0, 1'b1);
    bus.rd_en = 1'b1;
    bus.rd_sel = 1'b0;
    bus.rd_addr = '0;
    tick();
    bus.rd_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_img.delete();
    exp_ker.delete();
    check_reset();
    wait_idle();
    chk("late_img_count", bus.img_count, 0);
    chk("late_err", bus.err, 0);
    send(rnd_line(), 1'b0, 1'b1, 1'b1);
    wait_done();
    chk("post_img_count", bus.img_count, exp_img.size());
    rd(1'b0, 0, exp_img[0], "post_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
